fifo_param: RTL and testbench
=============================

FIFO_PARAM -- requirements
Module: fifo_param

Interface
REQ-001 Parameter DATA_W, default 8, width of w_data and r_data in bits.
REQ-002 Parameter ADDR_W, default 4, address width; depth DEPTH = 2^ADDR_W entries (default 16).
REQ-003 Parameter AF_THRESH, default 14, almost_full level; legal range AE_THRESH < AF_THRESH <= DEPTH.
REQ-004 Parameter AE_THRESH, default 2, almost_empty level; legal range 0 <= AE_THRESH < AF_THRESH.
REQ-005 CLK  in  1  single clock; all state changes on rising edge.
REQ-006 RESET  in  1  asynchronous, active-high reset.
REQ-007 wr  in  1  write request, sampled each rising edge.
REQ-008 rd  in  1  read request (pop head entry), sampled each rising edge.
REQ-009 w_data  in  DATA_W  write data.
REQ-010 flush  in  1  synchronous clear of contents.
REQ-011 err_clr  in  1  synchronous clear of sticky error flags.
REQ-012 r_data  out  DATA_W  head entry (first-word-fall-through).
REQ-013 empty  out  1  count == 0.
REQ-014 full  out  1  count == DEPTH.
REQ-015 almost_empty  out  1  count <= AE_THRESH.
REQ-016 almost_full  out  1  count >= AF_THRESH.
REQ-017 count  out  ADDR_W+1  number of stored entries, 0..DEPTH.
REQ-018 overflow  out  1  sticky: write attempted while full without concurrent read.
REQ-019 underflow  out  1  sticky: read attempted while empty.

Function
REQ-020 Storage: DEPTH x DATA_W register array, write pointer, read pointer (ADDR_W bits each, wrap modulo DEPTH), registered count.
REQ-021 Write accepted when wr=1 and (full=0 or rd=1); data stored at write pointer, pointer +1.
REQ-022 Read accepted when rd=1 and empty=0; read pointer +1.
REQ-023 count: +1 on accepted write only, -1 on accepted read only, unchanged when both or neither accepted.
REQ-024 wr=1, rd=1, full=1: both accepted; count stays DEPTH; full stays 1; overflow not set.
REQ-025 wr=1, rd=1, empty=1: write accepted, read rejected; count becomes 1; underflow set.
REQ-026 wr=1, full=1, rd=0: write rejected, memory and pointers unchanged, overflow set next edge.
REQ-027 rd=1, empty=1: no pointer change, underflow set next edge.
REQ-028 r_data combinationally equals array[read pointer]; a value written into an empty FIFO appears on r_data the edge after the write; r_data is don't-care while empty=1.
REQ-029 All status outputs derive only from registered state (pointers, count, flags); no combinational path from wr/rd to any output.
REQ-030 flush=1: read pointer, write pointer, count -> 0 next edge; overrides wr and rd that cycle (no write stored, no error flag set by that cycle); memory contents not cleared; overflow/underflow unaffected.
REQ-031 err_clr=1 clears overflow and underflow next edge; a new error in the same cycle takes priority (flag ends at 1).
REQ-032 Pointer wrap from DEPTH-1 to 0 preserves FIFO order with no lost or duplicated entry.

Reset
REQ-033 RESET=1 immediately (no clock): pointers 0, count 0, empty 1, full 0, almost_empty 1, almost_full 0, overflow 0, underflow 0; memory not reset.
REQ-034 RESET asserted mid-operation discards all contents; first accepted write after release lands at address 0.

Verification (DATA_W=8, ADDR_W=4, AF_THRESH=14, AE_THRESH=2)
REQ-035 Reset, write 1..16 -> almost_empty drops at count 3, almost_full rises at count 14, full=1 and count=16 after 16th; write 17 -> overflow=1, count 16, value 17 not stored.
REQ-036 Then 17 reads -> r_data sequence 1..16, empty=1 after 16th read, 17th read sets underflow=1; err_clr -> both flags 0.
REQ-037 Write 10 values, read 10, write 12 values (pointer wraps), read 12 -> exact write order returned, count returns to 0.
REQ-038 At full, wr=rd=1 one cycle -> count 16, full 1, overflow 0, head advances; at empty, wr=rd=1 with 0x55 -> count 1, r_data 0x55, underflow 1.
REQ-039 count=5, flush=1 with wr=1 -> count 0, empty 1, write discarded; err_clr with simultaneous underflow event -> underflow stays 1.
REQ-040 RESET asserted between clock edges with count=7 -> all outputs take REQ-033 values before next rising edge.

Source files
------------

// File: rtl/fifo_param.sv
// Synchronous single-clock FIFO with first-word-fall-through read data,
// programmable almost-empty/almost-full levels, flush, and sticky
// overflow/underflow flags. All status outputs decode registered state only.
module fifo_param #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 4,
  parameter int AF_THRESH = 14,
  parameter int AE_THRESH = 2
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              wr,
  input  logic              rd,
  input  logic [DATA_W-1:0] w_data,
  input  logic              flush,
  input  logic              err_clr,
  output logic [DATA_W-1:0] r_data,
  output logic              empty,
  output logic              full,
  output logic              almost_empty,
  output logic              almost_full,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              underflow
);

  localparam int DEPTH = 1 << ADDR_W;

  // Levels pre-sized to the count width so every compare is width-matched.
  localparam logic [ADDR_W:0]   DEPTH_LVL = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   AF_LVL    = (ADDR_W+1)'(AF_THRESH);
  localparam logic [ADDR_W:0]   AE_LVL    = (ADDR_W+1)'(AE_THRESH);
  localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE   = ADDR_W'(1);

  // Storage array; intentionally not reset so it can map onto plain RAM/regs.
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              overflow_q, overflow_d;
  logic              underflow_q, underflow_d;

  logic wr_accept;
  logic rd_accept;
  logic overflow_evt;
  logic underflow_evt;

  // Status decodes come straight from the registered count.
  assign empty        = (count_q == '0);
  assign full         = (count_q == DEPTH_LVL);
  assign almost_empty = (count_q <= AE_LVL);
  assign almost_full  = (count_q >= AF_LVL);
  assign count        = count_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

  // Head entry is always visible (first-word-fall-through).
  assign r_data = mem_q[rd_ptr_q];

  // A write into a full FIFO is still accepted when a read frees a slot in the
  // same cycle; flush suppresses every request for the cycle it is active.
  assign wr_accept     = wr && !flush && (!full || rd);
  assign rd_accept     = rd && !flush && !empty;
  assign overflow_evt  = wr && !flush && full && !rd;
  assign underflow_evt = rd && !flush && empty;

  // Next-state for pointers, occupancy and sticky error flags.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_accept) begin
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end
      if (rd_accept) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
      case ({wr_accept, rd_accept})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end

    // Clear first, then let a same-cycle error re-set the flag.
    if (err_clr) begin
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end
    if (overflow_evt) begin
      overflow_d = 1'b1;
    end
    if (underflow_evt) begin
      underflow_d = 1'b1;
    end
  end

  // Control state registers with asynchronous reset.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Store accepted write data at the write pointer.
  always_ff @(posedge CLK) begin
    if (wr_accept) begin
      mem_q[wr_ptr_q] <= w_data;
    end
  end

endmodule

// File: tb/tb_fifo_param.sv
// Directed self-checking bench for fifo_param at default parameters.
module tb_fifo_param;

  logic       CLK;
  logic       RESET;
  logic       wr;
  logic       rd;
  logic [7:0] w_data;
  logic       flush;
  logic       err_clr;
  logic [7:0] r_data;
  logic       empty;
  logic       full;
  logic       almost_empty;
  logic       almost_full;
  logic [4:0] count;
  logic       overflow;
  logic       underflow;

  int checks = 0;
  int errors = 0;

  fifo_param #(
    .DATA_W(8), .ADDR_W(4), .AF_THRESH(14), .AE_THRESH(2)
  ) dut (
    .CLK(CLK), .RESET(RESET), .wr(wr), .rd(rd), .w_data(w_data),
    .flush(flush), .err_clr(err_clr), .r_data(r_data), .empty(empty),
    .full(full), .almost_empty(almost_empty), .almost_full(almost_full),
    .count(count), .overflow(overflow), .underflow(underflow)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle with the given requests; returns 1 ns after the edge.
  task automatic cyc(input logic w, input logic r, input logic [7:0] d,
                     input logic f, input logic ec);
    wr = w; rd = r; w_data = d; flush = f; err_clr = ec;
    @(posedge CLK);
    #1;
    wr = 1'b0; rd = 1'b0; w_data = 8'h00; flush = 1'b0; err_clr = 1'b0;
    $display("t=%0t wr=%0b rd=%0b d=%02h flush=%0b err_clr=%0b -> count=%0d r_data=%02h ov=%0b uf=%0b",
             $time, w, r, d, f, ec, count, r_data, overflow, underflow);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_count"}, 32'(count), 32'd0);
    chk({tag, "_empty"}, 32'(empty), 32'd1);
    chk({tag, "_full"}, 32'(full), 32'd0);
    chk({tag, "_ae"}, 32'(almost_empty), 32'd1);
    chk({tag, "_af"}, 32'(almost_full), 32'd0);
    chk({tag, "_ov"}, 32'(overflow), 32'd0);
    chk({tag, "_uf"}, 32'(underflow), 32'd0);
  endtask

  initial begin
    RESET = 1'b1; wr = 1'b0; rd = 1'b0; w_data = 8'h00; flush = 1'b0; err_clr = 1'b0;
    #2;
    chk_reset_state("por");
    @(negedge CLK);
    RESET = 1'b0;

    // Fill 1..16, watching the threshold flags.
    for (int i = 1; i <= 16; i++) begin
      cyc(1'b1, 1'b0, 8'(i), 1'b0, 1'b0);
      chk("fill_count", 32'(count), 32'(i));
      chk("fill_ae", 32'(almost_empty), (i <= 2) ? 32'd1 : 32'd0);
      chk("fill_af", 32'(almost_full), (i >= 14) ? 32'd1 : 32'd0);
      chk("fill_full", 32'(full), (i == 16) ? 32'd1 : 32'd0);
      chk("fill_head", 32'(r_data), 32'd1);
    end
    cyc(1'b1, 1'b0, 8'd17, 1'b0, 1'b0);
    chk("ovf_flag", 32'(overflow), 32'd1);
    chk("ovf_count", 32'(count), 32'd16);
    chk("ovf_head", 32'(r_data), 32'd1);

    // Drain; value 17 must not appear.
    for (int i = 1; i <= 16; i++) begin
      chk("drain_data", 32'(r_data), 32'(i));
      cyc(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
      chk("drain_count", 32'(count), 32'(16 - i));
    end
    chk("drain_empty", 32'(empty), 32'd1);
    chk("drain_ov_sticky", 32'(overflow), 32'd1);
    chk("drain_uf_pre", 32'(underflow), 32'd0);
    cyc(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
    chk("udf_flag", 32'(underflow), 32'd1);
    chk("udf_count", 32'(count), 32'd0);
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    chk("clr_ov", 32'(overflow), 32'd0);
    chk("clr_uf", 32'(underflow), 32'd0);

    // Write 10 / read 10, then write 12 / read 12 across the pointer wrap.
    for (int i = 0; i < 10; i++) cyc(1'b1, 1'b0, 8'(8'hA0 + i), 1'b0, 1'b0);
    chk("w10_count", 32'(count), 32'd10);
    for (int i = 0; i < 10; i++) begin
      chk("r10_data", 32'(r_data), 32'(8'hA0 + i));
      cyc(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
    end
    for (int i = 0; i < 12; i++) cyc(1'b1, 1'b0, 8'(8'h30 + i), 1'b0, 1'b0);
    chk("w12_count", 32'(count), 32'd12);
    for (int i = 0; i < 12; i++) begin
      chk("r12_data", 32'(r_data), 32'(8'h30 + i));
      cyc(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
    end
    chk("wrap_count", 32'(count), 32'd0);
    chk("wrap_uf", 32'(underflow), 32'd0);

    // Simultaneous read/write at full.
    for (int i = 0; i < 16; i++) cyc(1'b1, 1'b0, 8'(8'h60 + i), 1'b0, 1'b0);
    chk("full_again", 32'(full), 32'd1);
    cyc(1'b1, 1'b1, 8'h99, 1'b0, 1'b0);
    chk("wrfull_count", 32'(count), 32'd16);
    chk("wrfull_full", 32'(full), 32'd1);
    chk("wrfull_ov", 32'(overflow), 32'd0);
    chk("wrfull_head", 32'(r_data), 32'h61);
    for (int i = 1; i < 16; i++) begin
      chk("wrfull_drain", 32'(r_data), 32'(8'h60 + i));
      cyc(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
    end
    chk("wrfull_last", 32'(r_data), 32'h99);
    cyc(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
    chk("wrfull_empty", 32'(empty), 32'd1);

    // Simultaneous read/write at empty.
    cyc(1'b1, 1'b1, 8'h55, 1'b0, 1'b0);
    chk("wrempty_count", 32'(count), 32'd1);
    chk("wrempty_data", 32'(r_data), 32'h55);
    chk("wrempty_uf", 32'(underflow), 32'd1);

    // Flush at count 5 with a concurrent write.
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    chk("clr2_uf", 32'(underflow), 32'd0);
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 8'(8'hC0 + i), 1'b0, 1'b0);
    chk("pre_flush_count", 32'(count), 32'd5);
    cyc(1'b1, 1'b0, 8'hEE, 1'b1, 1'b0);
    chk("flush_count", 32'(count), 32'd0);
    chk("flush_empty", 32'(empty), 32'd1);
    cyc(1'b0, 1'b1, 8'h00, 1'b1, 1'b0);
    chk("flush_rd_uf", 32'(underflow), 32'd0);
    chk("flush_rd_count", 32'(count), 32'd0);
    cyc(1'b1, 1'b0, 8'h11, 1'b0, 1'b0);
    chk("post_flush_count", 32'(count), 32'd1);
    chk("post_flush_data", 32'(r_data), 32'h11);
    cyc(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
    chk("post_flush_empty", 32'(empty), 32'd1);
    cyc(1'b0, 1'b1, 8'h00, 1'b0, 1'b1);
    chk("clr_vs_uf", 32'(underflow), 32'd1);

    // Asynchronous reset mid-cycle at count 7 (underflow still set).
    for (int i = 0; i < 7; i++) cyc(1'b1, 1'b0, 8'(8'h40 + i), 1'b0, 1'b0);
    chk("pre_rst_count", 32'(count), 32'd7);
    chk("pre_rst_uf", 32'(underflow), 32'd1);
    #3;
    RESET = 1'b1;
    #1;
    chk_reset_state("async");
    #2;
    RESET = 1'b0;
    cyc(1'b1, 1'b0, 8'h77, 1'b0, 1'b0);
    chk("post_rst_count", 32'(count), 32'd1);
    chk("post_rst_data", 32'(r_data), 32'h77);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
